dectape_rx: RTL and testbench

- Controller-side receive and motion sequencer for the TU56 drive interface.
- Drives unit select, direction and go lines to the drive.
- Recovers line strobes from the timing track and tracks the mark track to find frame/block marks.
- Assembles 3-bit data lines into 36-bit words for the KA10-side DECtape controller logic.

---
 rtl/dectape_pkg.sv | 13 +
 rtl/dectape_rx_edge_strobe.sv | 39 +++
 rtl/dectape_rx.sv | 158 +++++++++++++++
 tb/tb_dectape_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dectape_pkg.sv
// dectape_pkg: mark codes, FSM states and word geometry shared by the dectape_rx receiver.
package dectape_pkg;
  localparam logic [5:0] MK_END   = 6'o55;
  localparam logic [5:0] MK_REND  = 6'o22;
  localparam logic [5:0] MK_BLKM  = 6'o26;
  localparam logic [5:0] MK_DATA  = 6'o70;
  localparam logic [5:0] MK_FINAL = 6'o73;
  localparam int LINES_PER_WORD = 12;
  typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_ACCEL, ST_RUN, ST_STOP} state_e;
  function automatic logic is_mark(input logic [5:0] w);
    return w inside {MK_END, MK_REND, MK_BLKM, MK_DATA, MK_FINAL};
  endfunction
endpackage

// File: rtl/dectape_rx_edge_strobe.sv
// dt_edge_strobe: synchronises dt_read, strobes on timing rising edges, measures edge spacing and idle time.
module dt_edge_strobe #(
  parameter logic [23:0] TMO_CYCLES = 24'd600000,
  parameter logic [15:0] EDGE_MAX   = 16'd3300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [4:0] dt_read,
  output logic       strobe,
  output logic       mark,
  output logic [2:0] data,
  output logic       gap_ok,
  output logic       timeout
);
  logic [4:0] s1_q, s2_q;
  logic t_q;
  logic [23:0] cnt_q, cnt_d;
  assign strobe  = s2_q[0] & ~t_q;
  assign mark    = s2_q[1];
  assign data    = s2_q[4:2];
  assign gap_ok  = cnt_q <= {8'd0, EDGE_MAX};
  assign timeout = cnt_q >= TMO_CYCLES;
  // Saturates at the timeout so a stalled tape keeps reporting it.
  always_comb cnt_d = (strobe || restart) ? '0 : timeout ? cnt_q : cnt_q + 24'd1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      t_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= dt_read;
      s2_q  <= s1_q;
      t_q   <= s2_q[0];
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dectape_rx.sv
// dectape_rx: TU56 motion sequencer and line/mark/word receiver.
// Defining DT_CHECKSUM_EN adds a 6-bit data-region checksum (cksum, cksum_valid).
module dectape_rx
  import dectape_pkg::*;
#(
  parameter logic [23:0] TMO_CYCLES  = 24'd600000,
  parameter logic [15:0] SEL_CYCLES  = 16'd1000,
  parameter logic [7:0]  SPEED_EDGES = 8'd64,
  parameter logic [15:0] EDGE_MAX    = 16'd3300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_unit,
  input  logic        cmd_rev,
  input  logic        cmd_go,
  output logic [3:0]  dt_select,
  output logic        dt_go,
  output logic        dt_fwd,
  output logic        dt_rev,
  output logic        dt_all_halt,
  input  logic        dt_select_echo,
  input  logic        dt_wrt_echo,
  input  logic [4:0]  dt_read,
  output logic        up_to_speed,
  output logic        mark_valid,
  output logic [5:0]  mark_code,
  output logic        word_valid,
  output logic [35:0] word,
`ifdef DT_CHECKSUM_EN
  output logic [5:0]  cksum,
  output logic        cksum_valid,
`endif
  output logic        err_sel,
  output logic        err_tmo
);
  state_e st_q, st_d;
  logic [3:0] sel_q, sel_d, lcnt_q, lcnt_d;
  logic rev_q, rev_d, go_q, go_d, fwd_q, fwd_d, rpl_q, rpl_d, uts_q, uts_d, halt_q;
  logic mv_q, mv_d, wv_q, wv_d, esel_q, esel_d, etmo_q, etmo_d, in_data_q, in_data_d;
  logic [5:0] mc_q, mc_d, win_q, win_d, win_n;
  logic [35:0] word_q, word_d;
  logic [15:0] scnt_q, scnt_d;
  logic [7:0] spd_q, spd_d;
  logic strobe, mark, gap_ok, timeout, restart, accept, last, unused_ok;
  logic [2:0] data, dv;
`ifdef DT_CHECKSUM_EN
  logic [5:0] ck_q, ck_d;
  logic [2:0] half_q, half_d;
  logic ph_q, ph_d, ckv_q, ckv_d;
  assign cksum       = ck_q;
  assign cksum_valid = ckv_q;
`endif
  dt_edge_strobe #(.TMO_CYCLES(TMO_CYCLES), .EDGE_MAX(EDGE_MAX)) u_edge (
    .clk(clk), .reset(reset), .restart(restart), .dt_read(dt_read),
    .strobe(strobe), .mark(mark), .data(data), .gap_ok(gap_ok), .timeout(timeout)
  );
  assign unused_ok   = dt_wrt_echo;
  assign dv          = rev_q ? ~data : data;
  assign win_n       = {win_q[4:0], mark};
  assign last        = lcnt_q == 4'(LINES_PER_WORD - 1);
  // A timeout or lost echo in RUN pre-empts any command presented that cycle.
  assign cmd_ready   = ~halt_q & (st_q == ST_IDLE || (st_q == ST_RUN && !timeout && dt_select_echo));
  assign accept      = cmd_valid & cmd_ready;
  assign restart     = (st_d == ST_ACCEL && st_q != ST_ACCEL) || (st_d == ST_STOP && st_q != ST_STOP);
  assign dt_select   = sel_q;
  assign dt_go       = go_q;
  assign dt_fwd      = fwd_q;
  assign dt_rev      = rpl_q;
  assign dt_all_halt = halt_q;
  assign up_to_speed = uts_q;
  assign mark_valid  = mv_q;
  assign mark_code   = mc_q;
  assign word_valid  = wv_q;
  assign word        = word_q;
  assign err_sel     = esel_q;
  assign err_tmo     = etmo_q;
  always_comb begin
    st_d = st_q; sel_d = sel_q; rev_d = rev_q; go_d = go_q; uts_d = uts_q;
    fwd_d = 1'b0; rpl_d = 1'b0; mv_d = 1'b0; wv_d = 1'b0; mc_d = mc_q;
    esel_d = accept ? 1'b0 : esel_q;
    etmo_d = accept ? 1'b0 : etmo_q;
    scnt_d = scnt_q; spd_d = spd_q; win_d = win_q; lcnt_d = lcnt_q; word_d = word_q; in_data_d = in_data_q;
`ifdef DT_CHECKSUM_EN
    ck_d = ck_q; half_d = half_q; ph_d = ph_q; ckv_d = 1'b0;
`endif
    case (st_q)
      ST_IDLE: if (accept && cmd_go) begin
        st_d = ST_SELECT; sel_d = {1'b1, cmd_unit}; rev_d = cmd_rev; scnt_d = '0;
      end
      ST_SELECT: if (dt_select_echo) begin
        st_d = ST_ACCEL; go_d = 1'b1; fwd_d = ~rev_q; rpl_d = rev_q;
        spd_d = '0; win_d = '0; in_data_d = 1'b0; lcnt_d = '0;
      end else if (scnt_q == SEL_CYCLES) begin
        st_d = ST_IDLE; sel_d = '0; esel_d = 1'b1;
      end else scnt_d = scnt_q + 16'd1;
      ST_ACCEL, ST_RUN: if (timeout || !dt_select_echo) begin
        st_d = ST_IDLE; sel_d = '0; go_d = 1'b0; uts_d = 1'b0;
        etmo_d = timeout ? 1'b1 : etmo_d;
        esel_d = timeout ? esel_d : 1'b1;
      end else if (st_q == ST_ACCEL) begin
        if (strobe) begin
          spd_d = gap_ok ? spd_q + 8'd1 : '0;
          if (gap_ok && spd_q + 8'd1 == SPEED_EDGES) begin
            st_d = ST_RUN; uts_d = 1'b1;
          end
        end
      end else if (accept && !cmd_go) begin
        st_d = ST_STOP; go_d = 1'b0; uts_d = 1'b0;
      end else if (accept && cmd_rev != rev_q) begin
        st_d = ST_ACCEL; uts_d = 1'b0; rev_d = cmd_rev; fwd_d = ~cmd_rev; rpl_d = cmd_rev;
        spd_d = '0; win_d = '0; in_data_d = 1'b0; lcnt_d = '0;
      end else if (strobe) begin
        win_d = win_n;
        if (is_mark(win_n)) begin
          mv_d = 1'b1; mc_d = win_n; lcnt_d = '0; in_data_d = win_n == MK_DATA;
`ifdef DT_CHECKSUM_EN
          ckv_d = in_data_q && win_n != MK_DATA;
          ck_d = win_n == MK_DATA ? '0 : ck_q;
          ph_d = 1'b0;
`endif
        end else if (in_data_q) begin
          word_d = {word_q[32:0], dv};
          lcnt_d = last ? '0 : lcnt_q + 4'd1;
          wv_d = last;
`ifdef DT_CHECKSUM_EN
          ph_d = ~ph_q; half_d = dv;
          ck_d = ph_q ? ck_q ^ {half_q, dv} : ck_q;
`endif
        end
      end
      ST_STOP: if (timeout) begin
        st_d = ST_IDLE; sel_d = '0;
      end
      default: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= ST_IDLE; sel_q <= '0; rev_q <= 1'b0; go_q <= 1'b0; fwd_q <= 1'b0; rpl_q <= 1'b0;
      halt_q <= 1'b1; uts_q <= 1'b0; mv_q <= 1'b0; mc_q <= '0; wv_q <= 1'b0; word_q <= '0;
      esel_q <= 1'b0; etmo_q <= 1'b0; scnt_q <= '0; spd_q <= '0; win_q <= '0; lcnt_q <= '0;
      in_data_q <= 1'b0;
`ifdef DT_CHECKSUM_EN
      ck_q <= '0; half_q <= '0; ph_q <= 1'b0; ckv_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d; sel_q <= sel_d; rev_q <= rev_d; go_q <= go_d; fwd_q <= fwd_d; rpl_q <= rpl_d;
      halt_q <= 1'b0; uts_q <= uts_d; mv_q <= mv_d; mc_q <= mc_d; wv_q <= wv_d; word_q <= word_d;
      esel_q <= esel_d; etmo_q <= etmo_d; scnt_q <= scnt_d; spd_q <= spd_d; win_q <= win_d;
      lcnt_q <= lcnt_d; in_data_q <= in_data_d;
`ifdef DT_CHECKSUM_EN
      ck_q <= ck_d; half_q <= half_d; ph_q <= ph_d; ckv_q <= ckv_d;
`endif
    end
  end
endmodule

// File: tb/tb_dectape_rx.sv
// tb_dectape_rx: directed line tables and motion sequences for dectape_rx with shortened timing parameters.
module tb_dectape_rx;
  localparam int TMO = 300;
  localparam int SEL = 20;
  localparam int SPD = 8;
  localparam int HI = 8;
  localparam int LO = 8;

  typedef struct {
    logic m;
    logic [2:0] d;
    logic mv;
    logic [5:0] mc;
    logic wv;
    logic [35:0] w;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_rev = 1'b0, cmd_go = 1'b0;
  logic [2:0] cmd_unit = 3'd0;
  logic dt_select_echo = 1'b0, dt_wrt_echo = 1'b0;
  logic [4:0] dt_read = 5'd0;
  logic cmd_ready, dt_go, dt_fwd, dt_rev, dt_all_halt, up_to_speed, mark_valid, word_valid, err_sel, err_tmo;
  logic [3:0] dt_select;
  logic [5:0] mark_code;
  logic [35:0] word;
`ifdef DT_CHECKSUM_EN
  logic [5:0] cksum;
  logic cksum_valid;
`endif
  int checks = 0, errors = 0, wv_count = 0;

  dectape_rx #(.TMO_CYCLES(24'(TMO)), .SEL_CYCLES(16'(SEL)), .SPEED_EDGES(8'(SPD)), .EDGE_MAX(16'd40)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit),
    .cmd_rev(cmd_rev), .cmd_go(cmd_go), .dt_select(dt_select), .dt_go(dt_go), .dt_fwd(dt_fwd),
    .dt_rev(dt_rev), .dt_all_halt(dt_all_halt), .dt_select_echo(dt_select_echo), .dt_wrt_echo(dt_wrt_echo),
    .dt_read(dt_read), .up_to_speed(up_to_speed), .mark_valid(mark_valid), .mark_code(mark_code),
    .word_valid(word_valid), .word(word),
`ifdef DT_CHECKSUM_EN
    .cksum(cksum), .cksum_valid(cksum_valid),
`endif
    .err_sel(err_sel), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (word_valid) wv_count++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic line(input logic m, input logic [2:0] d, output logic mv, output logic [5:0] mc,
                      output logic wv, output logic [35:0] w);
    @(negedge clk) dt_read = {d, m, 1'b1};
    repeat (3) @(negedge clk);
    mv = mark_valid; mc = mark_code; wv = word_valid; w = word;
    repeat (HI - 3) @(negedge clk);
    dt_read = {d, m, 1'b0};
    repeat (LO) @(negedge clk);
  endtask

  task automatic run(input string name, input vec_t t[$]);
    logic mv, wv;
    logic [5:0] mc;
    logic [35:0] w;
    foreach (t[i]) begin
      line(t[i].m, t[i].d, mv, mc, wv, w);
      chk({name, "_mv"}, 64'(mv), 64'(t[i].mv));
      if (t[i].mv) chk({name, "_code"}, 64'(mc), 64'(t[i].mc));
      chk({name, "_wv"}, 64'(wv), 64'(t[i].wv));
      if (t[i].wv) chk({name, "_word"}, 64'(w), 64'(t[i].w));
    end
  endtask

  task automatic accel();
    logic mv, wv;
    logic [5:0] mc;
    logic [35:0] w;
    repeat (SPD - 1) line(1'b0, 3'd0, mv, mc, wv, w);
    chk("not_yet_speed", 64'(up_to_speed), 0);
    line(1'b0, 3'd0, mv, mc, wv, w);
    chk("up_to_speed", 64'(up_to_speed), 1);
  endtask

  task automatic cmd(input logic [2:0] u, input logic r, input logic g);
    @(negedge clk);
    cmd_unit = u; cmd_rev = r; cmd_go = g; cmd_valid = 1'b1;
    chk("cmd_ready", 64'(cmd_ready), 1);
    @(negedge clk) cmd_valid = 1'b0;
  endtask

  task automatic rst_outs(input string name);
    chk({name, "_outs"}, 64'({dt_select, dt_go, dt_fwd, dt_rev, up_to_speed, mark_valid, word_valid, err_sel, err_tmo}), 0);
    chk({name, "_word"}, 64'(word), 0);
    chk({name, "_halt"}, 64'(dt_all_halt), 1);
    chk({name, "_ready"}, 64'(cmd_ready), 0);
  endtask

  function automatic vec_t v(input logic m, input logic [2:0] d, input logic mv, input logic [5:0] mc,
                             input logic wv, input logic [35:0] w);
    v.m = m; v.d = d; v.mv = mv; v.mc = mc; v.wv = wv; v.w = w;
  endfunction

  vec_t fwd_tbl[$], rev_tbl[$], part_tbl[$], idle_tbl[$];
  logic [6:0] mseq;
  logic [5:0] fin;
  logic saw;
  int wv_saved;

  initial begin
    // Mark bits 0,1,1,1,0,0,0 walk the window to 6'o34 and then to MK_DATA.
    mseq = 7'b0111000;
    fin = 6'o73;
    for (int i = 0; i < 7; i++) begin
      fwd_tbl.push_back(v(mseq[6 - i], 3'd0, i == 6, 6'o70, 1'b0, '0));
      rev_tbl.push_back(v(mseq[6 - i], 3'd0, i == 6, 6'o70, 1'b0, '0));
      part_tbl.push_back(v(mseq[6 - i], 3'd0, i == 6, 6'o70, 1'b0, '0));
    end
    for (int i = 0; i < 12; i++) fwd_tbl.push_back(v(1'b0, 3'o5, 1'b0, '0, i == 11, 36'o555555555555));
    for (int i = 0; i < 12; i++) fwd_tbl.push_back(v(1'b0, 3'(i % 8), 1'b0, '0, i == 11, 36'o012345670123));
    for (int i = 0; i < 6; i++) fwd_tbl.push_back(v(fin[5 - i], 3'd0, i == 5, 6'o73, 1'b0, '0));
    for (int i = 0; i < 12; i++) fwd_tbl.push_back(v(1'b0, 3'o7, 1'b0, '0, 1'b0, '0));
    for (int i = 0; i < 12; i++) rev_tbl.push_back(v(1'b0, 3'o2, 1'b0, '0, i == 11, 36'o555555555555));
    for (int i = 0; i < 7; i++) part_tbl.push_back(v(1'b0, 3'o5, 1'b0, '0, 1'b0, '0));
    for (int i = 0; i < 5; i++) idle_tbl.push_back(v(1'b0, 3'o5, 1'b0, '0, 1'b0, '0));

    repeat (3) @(negedge clk);
    rst_outs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("halt_release", 64'(dt_all_halt), 0);

    // No echo: select error one cycle after the select window.
    cmd(3'd3, 1'b0, 1'b1);
    chk("select_drive", 64'(dt_select), 4'b1011);
    repeat (SEL) @(negedge clk);
    chk("err_sel_early", 64'(err_sel), 0);
    @(negedge clk);
    chk("err_sel", 64'(err_sel), 1);
    chk("sel_drop", 64'(dt_select), 0);
    chk("sel_idle_ready", 64'(cmd_ready), 1);

    // Forward start with a late echo.
    cmd(3'd3, 1'b0, 1'b1);
    chk("err_sel_clear", 64'(err_sel), 0);
    repeat (9) @(negedge clk);
    dt_select_echo = 1'b1;
    @(negedge clk);
    chk("fwd_pulse", 64'({dt_fwd, dt_rev, dt_go}), 3'b101);
    @(negedge clk);
    chk("fwd_pulse_end", 64'(dt_fwd), 0);
    accel();
    run("fwd", fwd_tbl);

    // Reverse in RUN re-accelerates; repeating the same direction does nothing.
    cmd(3'd3, 1'b1, 1'b1);
    chk("rev_pulse", 64'({dt_rev, dt_fwd, up_to_speed}), 3'b100);
    accel();
    cmd(3'd3, 1'b1, 1'b1);
    chk("same_dir", 64'({dt_rev, up_to_speed}), 2'b01);
    run("rev", rev_tbl);

    // Timing stops in RUN.
    repeat (TMO / 2) @(negedge clk);
    chk("tmo_early", 64'({err_tmo, dt_go}), 2'b01);
    saw = 1'b0;
    for (int i = 0; i < TMO + 50 && dt_go; i++) begin
      @(negedge clk);
      if (dt_go && !cmd_ready) saw = 1'b1;
    end
    chk("tmo_blocks_cmd", 64'(saw), 1);
    chk("err_tmo", 64'({err_tmo, dt_go, dt_select}), 6'b100000);

    // Reset after line 7 of a word.
    cmd(3'd3, 1'b0, 1'b1);
    chk("err_tmo_clear", 64'(err_tmo), 0);
    accel();
    run("part", part_tbl);
    @(negedge clk) reset = 1'b0;
    #1;
    rst_outs("midreset");
    wv_saved = wv_count;
    @(negedge clk) reset = 1'b1;
    run("after_reset", idle_tbl);
    chk("no_partial_word", 64'(wv_count), 64'(wv_saved));

    // Stop command, then deselect once the tape has gone quiet.
    repeat (2) @(negedge clk);
    cmd(3'd3, 1'b0, 1'b1);
    accel();
    cmd(3'd3, 1'b0, 1'b0);
    chk("stop", 64'({dt_go, cmd_ready, up_to_speed}), 0);
    repeat (TMO + 10) @(negedge clk);
    chk("stop_idle", 64'({dt_select, cmd_ready, err_tmo}), 6'b000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
